// File: rtl/cordic_issue_wb.sv
// cordic_issue_wb
// Issue/writeback wrapper around the fixed-latency, non-stallable cordic_fu.
//   clk, rst            clock and synchronous active-high reset
//   req_*               dispatch request (valid/ready handshake, func, operands, tag)
//   fu_*_in / fu_op*    drive the cordic_fu inputs
//   fu_valid_out, ...   cordic_fu results, override and func
//   wb_*                writeback FIFO head (valid/ready handshake)
//   seq_err             sticky FU-valid / tag-line mismatch or capture overflow
// Every accepted request holds one credit until its result leaves the output FIFO,
// so a result arriving from the FU always finds a free FIFO slot.
module cordic_issue_wb #(
    parameter int FU_LATENCY = 7,
    parameter int TAG_W      = 5,
    parameter int OUT_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_func,
    input  logic [17:0]      req_op1,
    input  logic [17:0]      req_op2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             fu_valid_in,
    output logic [4:0]       fu_func_in,
    output logic [17:0]      fu_op1,
    output logic [17:0]      fu_op2,
    input  logic             fu_valid_out,
    input  logic [4:0]       fu_func_out,
    input  logic [25:0]      fu_result,
    input  logic             fu_override,
    input  logic [17:0]      fu_override_val,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_func,
    output logic [TAG_W-1:0] wb_tag,
    output logic [17:0]      wb_data,
    output logic             seq_err
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BLK_W = $clog2(FU_LATENCY + 1);
    localparam int ENT_W = 5 + TAG_W + 18;

    logic [BLK_W-1:0]  blank_cnt_q, blank_cnt_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FU_LATENCY-1:0] line_vld_q, line_vld_d;
    logic [TAG_W-1:0]  line_tag_q [FU_LATENCY];
    logic [TAG_W-1:0]  line_tag_d [FU_LATENCY];
    logic [ENT_W-1:0]  mem_q [OUT_DEPTH];
    logic [ENT_W-1:0]  mem_d [OUT_DEPTH];
    logic              seq_err_q, seq_err_d;

    logic              blank_s, accept_s, exit_vld_s, push_s, pop_s;
    logic              fifo_full_s, wr_ok_s, overflow_s, mismatch_s;
    logic [CNT_W:0]    credit_use_s;
    logic [TAG_W-1:0]  exit_tag_s;
    logic [17:0]       cap_data_s;
    logic [ENT_W-1:0]  head_s;
    logic              unused_lsb_s;

    // Credits, handshakes and tag-line exit; stale FU outputs are ignored while blanking.
    always_comb begin
        blank_s      = (blank_cnt_q != BLK_W'(0));
        credit_use_s = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
        req_ready    = !blank_s && (credit_use_s < (CNT_W+1)'(OUT_DEPTH));
        accept_s     = req_valid & req_ready;
        exit_vld_s   = line_vld_q[FU_LATENCY-1];
        exit_tag_s   = line_tag_q[FU_LATENCY-1];
        push_s       = exit_vld_s & ~blank_s;
        pop_s        = wb_valid & wb_ready;
        fifo_full_s  = (fifo_cnt_q == CNT_W'(OUT_DEPTH));
        // A full FIFO can still take a write when the head leaves in the same cycle.
        wr_ok_s      = push_s & (~fifo_full_s | pop_s);
        overflow_s   = push_s & fifo_full_s & ~pop_s;
        mismatch_s   = ~blank_s & (fu_valid_out != exit_vld_s);
        cap_data_s   = fu_override ? fu_override_val : fu_result[25:8];
        unused_lsb_s = ^fu_result[7:0];
    end

    // Issue pass-through and writeback head fields.
    always_comb begin
        fu_valid_in = accept_s;
        fu_func_in  = req_func;
        fu_op1      = req_op1;
        fu_op2      = req_op2;
        head_s      = mem_q[rd_ptr_q];
        wb_valid    = (fifo_cnt_q != CNT_W'(0));
        wb_func     = head_s[ENT_W-1 -: 5];
        wb_tag      = head_s[18 +: TAG_W];
        wb_data     = head_s[17:0];
        seq_err     = seq_err_q;
    end

    // Next-state for blanking, credits, tag line, FIFO and sticky error.
    always_comb begin
        if (blank_s) begin
            blank_cnt_d = blank_cnt_q - BLK_W'(1);
        end else begin
            blank_cnt_d = blank_cnt_q;
        end

        case ({accept_s, exit_vld_s})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        // Entry 0 takes req_tag every cycle; only the valid bit is meaningful.
        line_vld_d    = {line_vld_q[FU_LATENCY-2:0], accept_s};
        line_tag_d[0] = req_tag;
        for (int i = 1; i < FU_LATENCY; i++) begin
            line_tag_d[i] = line_tag_q[i-1];
        end

        case ({wr_ok_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        mem_d = mem_q;
        if (wr_ok_s) begin
            mem_d[wr_ptr_q] = {fu_func_out, exit_tag_s, cap_data_s};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        seq_err_d = seq_err_q | mismatch_s | overflow_s;
    end

    // State registers with synchronous reset; blanking restarts on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_cnt_q <= BLK_W'(FU_LATENCY);
            inflight_q  <= CNT_W'(0);
            fifo_cnt_q  <= CNT_W'(0);
            wr_ptr_q    <= PTR_W'(0);
            rd_ptr_q    <= PTR_W'(0);
            line_vld_q  <= FU_LATENCY'(0);
            seq_err_q   <= 1'b0;
            for (int i = 0; i < FU_LATENCY; i++) begin
                line_tag_q[i] <= TAG_W'(0);
            end
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= ENT_W'(0);
            end
        end else begin
            blank_cnt_q <= blank_cnt_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            line_vld_q  <= line_vld_d;
            seq_err_q   <= seq_err_d;
            line_tag_q  <= line_tag_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: tb/tb_cordic_issue_wb.sv
// Self-checking bench for cordic_issue_wb. The bench plays the role of cordic_fu
// (fixed 7-cycle latency, no reset) and keeps a queue-based reference model:
// credits = accepted - popped, expected writeback order = FU completion order.
module tb_cordic_issue_wb;
    localparam int LAT   = 7;
    localparam int TW    = 5;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [4:0]    req_func = 5'd0;
    logic [17:0]   req_op1 = 18'd0, req_op2 = 18'd0;
    logic [TW-1:0] req_tag = 5'd0;
    logic          fu_valid_in;
    logic [4:0]    fu_func_in;
    logic [17:0]   fu_op1, fu_op2;
    logic          fu_valid_out = 1'b0;
    logic [4:0]    fu_func_out = 5'd0;
    logic [25:0]   fu_result = 26'd0;
    logic          fu_override = 1'b0;
    logic [17:0]   fu_override_val = 18'd0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [4:0]    wb_func;
    logic [TW-1:0] wb_tag;
    logic [17:0]   wb_data;
    logic          seq_err;

    always #5 clk = ~clk;

    cordic_issue_wb #(.FU_LATENCY(LAT), .TAG_W(TW), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
        .fu_valid_in(fu_valid_in), .fu_func_in(fu_func_in), .fu_op1(fu_op1), .fu_op2(fu_op2),
        .fu_valid_out(fu_valid_out), .fu_func_out(fu_func_out), .fu_result(fu_result),
        .fu_override(fu_override), .fu_override_val(fu_override_val),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_func(wb_func), .wb_tag(wb_tag),
        .wb_data(wb_data), .seq_err(seq_err)
    );

    // Bench FU schedule, indexed by cycle number modulo 16.
    logic          s_v   [16];
    logic          s_trk [16];
    logic [4:0]    s_func[16];
    logic [TW-1:0] s_tag [16];
    logic [25:0]   s_res [16];
    logic          s_ovr [16];
    logic [17:0]   s_oval[16];

    logic [27:0] exp_q[$];
    int   cyc = 0, outstanding = 0, post_rst = 0;
    int   checks = 0, errors = 0, acc_cnt = 0;
    bit   armed = 1'b0, seq_exp = 1'b0, inject = 1'b0, last_accept = 1'b0;
    bit   force_en = 1'b0, force_ovr = 1'b0;
    logic [25:0] force_res = 26'd0;
    logic [17:0] force_oval = 18'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_req(input bit v, input logic [TW-1:0] t);
        req_valid = v;
        req_tag   = t;
        req_func  = 5'($urandom);
        req_op1   = 18'($urandom);
        req_op2   = 18'($urandom);
    endtask

    // One clock cycle: drive FU outputs, check at negedge, advance model at posedge.
    task automatic tick();
        int slot, nslot;
        bit blank, ready_exp, wbv_exp, accept_m, pop_m, fvo, trk_exit, vin;
        logic [4:0] fin;
        logic [17:0] data;
        slot            = cyc % 16;
        fvo             = s_v[slot] | inject;
        trk_exit        = s_v[slot] & s_trk[slot];
        fu_valid_out    = fvo;
        fu_func_out     = s_func[slot];
        fu_result       = s_res[slot];
        fu_override     = s_ovr[slot];
        fu_override_val = s_oval[slot];
        @(negedge clk);
        blank     = (post_rst < LAT);
        ready_exp = !blank && (outstanding < DEPTH);
        wbv_exp   = (exp_q.size() != 0);
        accept_m  = req_valid && ready_exp;
        pop_m     = wbv_exp && wb_ready;
        vin       = fu_valid_in;
        fin       = fu_func_in;
        if (armed) begin
            check("req_ready", 64'(req_ready), 64'(ready_exp));
            check("fu_valid_in", 64'(fu_valid_in), 64'(accept_m));
            check("fu_passthru", 64'({fu_func_in, fu_op1, fu_op2}), 64'({req_func, req_op1, req_op2}));
            check("wb_valid", 64'(wb_valid), 64'(wbv_exp));
            check("seq_err", 64'(seq_err), 64'(seq_exp));
            if (wbv_exp) check("wb_entry", 64'({wb_func, wb_tag, wb_data}), 64'(exp_q[0]));
        end
        if (vin) acc_cnt++;
        @(posedge clk);
        if (pop_m) void'(exp_q.pop_front());
        if (!blank && trk_exit) begin
            data = s_ovr[slot] ? s_oval[slot] : s_res[slot][25:8];
            exp_q.push_back({s_func[slot], s_tag[slot], data});
        end
        if (!rst && !blank && (fvo != trk_exit)) seq_exp = 1'b1;
        if (!rst) outstanding += int'(accept_m) - int'(pop_m);
        s_v[slot]   = 1'b0;
        s_trk[slot] = 1'b0;
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            seq_exp     = 1'b0;
            post_rst    = 0;
            armed       = 1'b1;
            for (int i = 0; i < 16; i++) s_trk[i] = 1'b0;
        end else if (post_rst < 1000) begin
            post_rst++;
        end
        // The FU reacts to what the DUT actually issued; the model tracks what it expected.
        if (vin) begin
            nslot         = (cyc + LAT) % 16;
            s_v[nslot]    = 1'b1;
            s_trk[nslot]  = accept_m && !rst;
            s_func[nslot] = fin;
            s_tag[nslot]  = req_tag;
            s_res[nslot]  = force_en ? force_res : 26'($urandom);
            s_ovr[nslot]  = force_en ? force_ovr : ($urandom_range(3) == 0);
            s_oval[nslot] = force_en ? force_oval : 18'($urandom);
        end
        last_accept = accept_m;
        cyc++;
        #1;
    endtask

    initial begin
        int sent, guard;
        for (int i = 0; i < 16; i++) begin
            s_v[i] = 1'b0; s_trk[i] = 1'b0; s_func[i] = 5'd0; s_tag[i] = 5'd0;
            s_res[i] = 26'd0; s_ovr[i] = 1'b0; s_oval[i] = 18'd0;
        end
        #1;
        repeat (3) tick();

        // Reset release: blanking, stale FU valid in cycle 3 is ignored.
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            inject = (n == 3);
            tick();
        end
        inject = 1'b0;

        // Single op, truncated result.
        wb_ready  = 1'b1;
        force_en  = 1'b1; force_ovr = 1'b0; force_res = 26'h3FFFF00; force_oval = 18'h0;
        rand_req(1'b1, 5'd5);
        tick();
        force_en = 1'b0;
        req_valid = 1'b0;
        repeat (10) tick();

        // Override replaces the result.
        force_en  = 1'b1; force_ovr = 1'b1; force_res = 26'($urandom); force_oval = 18'h00123;
        rand_req(1'b1, 5'd9);
        tick();
        force_en = 1'b0;
        req_valid = 1'b0;
        repeat (10) tick();

        // Backpressure: exactly DEPTH credits, then release.
        wb_ready = 1'b0;
        acc_cnt  = 0;
        sent     = 0;
        for (int n = 0; n < 12; n++) begin
            rand_req(1'b1, 5'(sent));
            tick();
            if (last_accept) sent++;
        end
        check("bp_accepts", 64'(acc_cnt), 64'(8));
        req_valid = 1'b0;
        repeat (8) tick();
        wb_ready = 1'b1;
        repeat (12) tick();

        // Streaming 32 requests with wb_ready held high.
        acc_cnt = 0;
        sent    = 0;
        guard   = 0;
        while (sent < 32 && guard < 200) begin
            rand_req(1'b1, 5'(sent));
            tick();
            if (last_accept) sent++;
            guard++;
        end
        check("stream_done", 64'(sent), 64'(32));
        check("stream_accepts", 64'(acc_cnt), 64'(32));
        req_valid = 1'b0;
        repeat (12) tick();

        // Randomized traffic and backpressure.
        for (int n = 0; n < 400; n++) begin
            rand_req($urandom_range(3) != 0, 5'($urandom));
            wb_ready = ($urandom_range(9) < 7);
            tick();
        end
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        repeat (20) tick();
        check("drained", 64'(exp_q.size()), 64'(0));

        // FU valid with nothing in flight: sticky seq_err until reset.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
